// File: rtl/iot_event_scheduler.sv
// Edge-detecting event scheduler: serialises per-device connect/disconnect events
// into change/on_off/dev_id strobes with round-robin fairness. Optional IOT_SHADOW_COUNT_EN adds shadow_count.
module iot_event_scheduler #(
    parameter int unsigned N_DEV = 8,
    parameter int unsigned ID_W  = $clog2(N_DEV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_DEV-1:0] dev_active,
    input  logic             hold,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic             pending
`ifdef IOT_SHADOW_COUNT_EN
    ,
    output logic [7:0]       shadow_count
`endif
);

    localparam int unsigned IDX_W = ID_W + 1;

    logic [N_DEV-1:0] prev;
    logic [N_DEV-1:0] pend_on;
    logic [N_DEV-1:0] pend_off;
    logic [N_DEV-1:0] pend_on_nxt;
    logic [N_DEV-1:0] pend_off_nxt;
    logic [N_DEV-1:0] req;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_ptr_nxt;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_vld;
    logic             change_nxt;
    logic             on_off_nxt;
    logic [ID_W-1:0]  dev_id_nxt;
    logic [IDX_W-1:0] idx;

    assign req = pend_on | pend_off;

    // Round-robin search starting just above the last granted index
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 1; k <= int'(N_DEV); k++) begin
            idx = IDX_W'({1'b0, rr_ptr}) + IDX_W'(k);
            if (idx >= IDX_W'(N_DEV)) begin
                idx = idx - IDX_W'(N_DEV);
            end
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
        if (hold) begin
            gnt_vld = 1'b0;
        end
    end

    // Grant clears the winner first; new edges then set or cancel pending state
    always_comb begin
        pend_on_nxt  = pend_on;
        pend_off_nxt = pend_off;
        rr_ptr_nxt   = rr_ptr;
        change_nxt   = 1'b0;
        on_off_nxt   = 1'b0;
        dev_id_nxt   = '0;
        if (gnt_vld) begin
            change_nxt            = 1'b1;
            on_off_nxt            = pend_on[gnt_idx];
            dev_id_nxt            = gnt_idx;
            rr_ptr_nxt            = gnt_idx;
            pend_on_nxt[gnt_idx]  = 1'b0;
            pend_off_nxt[gnt_idx] = 1'b0;
        end
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (dev_active[i] && !prev[i]) begin
                if (pend_off_nxt[i]) begin
                    pend_off_nxt[i] = 1'b0;
                end else begin
                    pend_on_nxt[i] = 1'b1;
                end
            end else if (!dev_active[i] && prev[i]) begin
                if (pend_on_nxt[i]) begin
                    pend_on_nxt[i] = 1'b0;
                end else begin
                    pend_off_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            pend_on  <= '0;
            pend_off <= '0;
            rr_ptr   <= ID_W'(N_DEV - 1);
            change   <= 1'b0;
            on_off   <= 1'b0;
            dev_id   <= '0;
            pending  <= 1'b0;
        end else begin
            prev     <= dev_active;
            pend_on  <= pend_on_nxt;
            pend_off <= pend_off_nxt;
            rr_ptr   <= rr_ptr_nxt;
            change   <= change_nxt;
            on_off   <= on_off_nxt;
            dev_id   <= dev_id_nxt;
            pending  <= |(pend_on_nxt | pend_off_nxt);
        end
    end

`ifdef IOT_SHADOW_COUNT_EN
    // Mirrors the downstream monitor count, one cycle ahead of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_count <= 8'd0;
        end else if (gnt_vld) begin
            shadow_count <= pend_on[gnt_idx] ? shadow_count + 8'd1 : shadow_count - 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_iot_event_scheduler.sv
// Self-checking bench for iot_event_scheduler: directed scenarios plus randomized
// traffic compared cycle by cycle against a per-device net-delta reference model.
module tb_iot_event_scheduler;

    localparam int unsigned N    = 8;
    localparam int unsigned ID_W = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    dev_active;
    logic            hold;
    logic            change;
    logic            on_off;
    logic [ID_W-1:0] dev_id;
    logic            pending;
`ifdef IOT_SHADOW_COUNT_EN
    logic [7:0]      shadow_count;
`endif

    iot_event_scheduler #(.N_DEV(N), .ID_W(ID_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dev_active   (dev_active),
        .hold         (hold),
        .change       (change),
        .on_off       (on_off),
        .dev_id       (dev_id),
        .pending      (pending)
`ifdef IOT_SHADOW_COUNT_EN
        ,
        .shadow_count (shadow_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: each device holds a net delta (+1 on owed, -1 off owed, 0 nothing)
    int m_pend [N];
    bit m_prev [N];
    int m_rr;
    bit e_change;
    bit e_onoff;
    int e_id;
    bit e_pending;
    int m_shadow;
    int net_emitted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_pend[i] = 0;
            m_prev[i] = 1'b0;
        end
        m_rr        = int'(N) - 1;
        e_change    = 1'b0;
        e_onoff     = 1'b0;
        e_id        = 0;
        e_pending   = 1'b0;
        m_shadow    = 0;
        net_emitted = 0;
    endtask

    task automatic model_step(input logic [N-1:0] da, input logic h);
        int g;
        g = -1;
        if (!h) begin
            for (int k = 1; k <= int'(N); k++) begin
                int j;
                j = (m_rr + k) % int'(N);
                if (g < 0 && m_pend[j] != 0) g = j;
            end
        end
        if (g >= 0) begin
            e_change  = 1'b1;
            e_onoff   = (m_pend[g] > 0);
            e_id      = g;
            m_rr      = g;
            m_shadow  = (m_shadow + m_pend[g] + 256) % 256;
            m_pend[g] = 0;
        end else begin
            e_change = 1'b0;
            e_onoff  = 1'b0;
            e_id     = 0;
        end
        e_pending = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (da[i] && !m_prev[i]) m_pend[i] = m_pend[i] + 1;
            if (!da[i] && m_prev[i]) m_pend[i] = m_pend[i] - 1;
            m_prev[i] = da[i];
            if (m_pend[i] != 0) e_pending = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".change"},  32'(change),  32'(e_change));
        chk({tag, ".on_off"},  32'(on_off),  32'(e_onoff));
        chk({tag, ".dev_id"},  32'(dev_id),  32'(e_id));
        chk({tag, ".pending"}, 32'(pending), 32'(e_pending));
`ifdef IOT_SHADOW_COUNT_EN
        chk({tag, ".shadow"},  32'(shadow_count), 32'(m_shadow));
`endif
    endtask

    task automatic cycle(input logic [N-1:0] da, input logic h, input string tag);
        dev_active = da;
        hold       = h;
        model_step(da, h);
        @(posedge clk);
        #1;
        if (change === 1'b1) net_emitted += (on_off === 1'b1) ? 1 : -1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        check_outputs({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] da;
        rst_n      = 1'b0;
        dev_active = '0;
        hold       = 1'b0;
        do_reset("reset0");

        // Single event: device 2 turns on
        cycle(8'h00, 1'b0, "idle");
        cycle(8'h04, 1'b0, "single_edge");
        chk("single_pend", 32'(pending), 32'd1);
        chk("single_nochg", 32'(change), 32'd0);
        cycle(8'h04, 1'b0, "single_emit");
        chk("single_chg", 32'(change), 32'd1);
        chk("single_dir", 32'(on_off), 32'd1);
        chk("single_id", 32'(dev_id), 32'd2);
        chk("single_clr", 32'(pending), 32'd0);
        cycle(8'h00, 1'b0, "off2");
        cycle(8'h00, 1'b0, "off2_emit");
        cycle(8'h00, 1'b0, "off2_idle");

        // Reset while three off events are held back
        for (int i = 0; i < 5; i++) cycle(8'h07, 1'b0, "pre_burst");
        cycle(8'h00, 1'b1, "fall3");
        cycle(8'h00, 1'b1, "fall3_hold");
        chk("fall3_pend", 32'(pending), 32'd1);
        do_reset("reset_mid");
        for (int i = 0; i < 4; i++) begin
            cycle(8'h00, 1'b0, "post_reset");
            chk("post_reset_quiet", 32'(change), 32'd0);
        end

        // Burst of eight simultaneous rises, emitted in index order
        cycle(8'hFF, 1'b0, "burst_edge");
        for (int i = 0; i < int'(N); i++) begin
            cycle(8'hFF, 1'b0, "burst");
            chk("burst_id", 32'(dev_id), 32'(i));
            chk("burst_dir", 32'(on_off), 32'd1);
        end
        cycle(8'hFF, 1'b0, "burst_done");
        chk("burst_clr", 32'(pending), 32'd0);
        for (int i = 0; i < int'(N) + 1; i++) cycle(8'h00, 1'b0, "burst_off");

        // Device 5 on then off under hold: net zero, nothing emitted
        cycle(8'h20, 1'b1, "cancel_rise");
        cycle(8'h00, 1'b1, "cancel_fall");
        for (int i = 0; i < 3; i++) begin
            cycle(8'h00, 1'b0, "cancel_rel");
            chk("cancel_quiet", 32'(change), 32'd0);
        end
        chk("cancel_clr", 32'(pending), 32'd0);

        // Hold accumulates devices 1 and 3
        for (int i = 0; i < 3; i++) begin
            cycle(8'h0A, 1'b1, "acc_hold");
            chk("acc_quiet", 32'(change), 32'd0);
        end
        cycle(8'h0A, 1'b0, "acc_rel1");
        chk("acc_id1", 32'(dev_id), 32'd1);
        cycle(8'h0A, 1'b0, "acc_rel2");
        chk("acc_id3", 32'(dev_id), 32'd3);

        // Randomized traffic with sparse toggles and intermittent hold
        da = 8'h0A;
        for (int n = 0; n < 3000; n++) begin
            logic [N-1:0] flip;
            flip = '0;
            for (int i = 0; i < int'(N); i++) flip[i] = ($urandom_range(0, 5) == 0);
            da = da ^ flip;
            cycle(da, ($urandom_range(0, 3) == 0), "rand");
        end
        for (int i = 0; i < int'(N) + 2; i++) cycle(da, 1'b0, "drain");
        chk("drain_clr", 32'(pending), 32'd0);
        chk("net_consistency", 32'(net_emitted), 32'($countones(da)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
